// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the UART instruction-memory loader.
// IMEM_LOADER_CHECKSUM_EN adds the checksum state to the loader state enum.
package imem_loader_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        StLen0, StLen1, StData, StChk, StDone, StErr
    } loader_state_e;
`else
    typedef enum logic [2:0] {
        StLen0, StLen1, StData, StDone, StErr
    } loader_state_e;
`endif

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-FF synchronizer, mid-bit sampling, glitch-rejecting start
// detection and stop-bit check. Emits one-cycle byte_valid_o / frame_err_o pulses.
module uart_rx_byte #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_o,
    output logic       frame_err_o
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CntW-1:0] HalfCnt = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

    rx_state_e       state_q, state_d;
    logic [1:0]      sync_q, sync_d;
    logic            prev_q, prev_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            valid_q, valid_d;
    logic            ferr_q, ferr_d;
    logic            rx_s;

    always_comb begin
        sync_d  = {sync_q[0], rx_i};
        rx_s    = sync_q[1];
        prev_d  = rx_s;
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            RxIdle: begin
                if (!rx_s && prev_q) begin
                    state_d = RxStart;
                    cnt_d   = '0;
                end
            end
            RxStart: begin
                // Line back high at half a bit means the start edge was a glitch.
                if (cnt_q == HalfCnt) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_s ? RxIdle : RxData;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RxData: begin
                if (cnt_q == FullCnt) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = RxStop;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RxStop: begin
                if (cnt_q == FullCnt) begin
                    cnt_d   = '0;
                    valid_d = rx_s;
                    ferr_d  = !rx_s;
                    state_d = RxIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = RxIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RxIdle;
            sync_q  <= 2'b11;
            prev_q  <= 1'b1;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign byte_valid_o = valid_q;
    assign byte_o       = shift_q;
    assign frame_err_o  = ferr_q;

endmodule

// File: rtl/imem_uart_loader.sv
// Boot loader: receives a length-prefixed image over UART and writes it into instruction
// memory, holding the core in reset until done. IMEM_LOADER_CHECKSUM_EN enables XOR checksum.
module imem_uart_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned ADDR_WIDTH   = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  uart_rx,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  core_resetn,
    output logic                  load_done,
    output logic                  load_error
);

    localparam int unsigned MaxWords = 1 << ADDR_WIDTH;

    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       rx_ferr;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk         (clk),
        .reset       (reset),
        .rx_i        (uart_rx),
        .byte_valid_o(rx_valid),
        .byte_o      (rx_byte),
        .frame_err_o (rx_ferr)
    );

    loader_state_e         state_q, state_d;
    logic [7:0]            len_lo_q, len_lo_d;
    logic [15:0]           words_left_q, words_left_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [23:0]           word_q, word_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  we_q, we_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [15:0]           n_words;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]            csum_q, csum_d;
`endif

    always_comb begin
        state_d      = state_q;
        len_lo_d     = len_lo_q;
        words_left_d = words_left_q;
        byte_cnt_d   = byte_cnt_q;
        word_d       = word_q;
        addr_d       = addr_q;
        we_d         = 1'b0;
        wdata_d      = wdata_q;
        n_words      = {rx_byte, len_lo_q};
        // Address saturates rather than wrapping after a full-memory image.
        if (we_q && addr_q != '1) addr_d = addr_q + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d = csum_q;
        if (rx_valid && (state_q == StLen0 || state_q == StLen1 || state_q == StData)) begin
            csum_d = csum_q ^ rx_byte;
        end
`endif
        case (state_q)
            StLen0: begin
                if (rx_ferr) begin
                    state_d = StErr;
                end else if (rx_valid) begin
                    len_lo_d = rx_byte;
                    state_d  = StLen1;
                end
            end
            StLen1: begin
                if (rx_ferr) begin
                    state_d = StErr;
                end else if (rx_valid) begin
                    if (32'(n_words) > MaxWords) begin
                        state_d = StErr;
                    end else if (n_words == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_d = StChk;
`else
                        state_d = StDone;
`endif
                    end else begin
                        words_left_d = n_words;
                        byte_cnt_d   = '0;
                        state_d      = StData;
                    end
                end
            end
            StData: begin
                if (rx_ferr) begin
                    state_d = StErr;
                end else if (rx_valid) begin
                    if (byte_cnt_q == 2'(BYTES_PER_WORD - 1)) begin
                        we_d         = 1'b1;
                        wdata_d      = {rx_byte, word_q};
                        words_left_d = words_left_q - 16'd1;
                        byte_cnt_d   = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        if (words_left_q == 16'd1) state_d = StChk;
`endif
                    end else begin
                        word_d     = {rx_byte, word_q[23:8]};
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end
`ifndef IMEM_LOADER_CHECKSUM_EN
                if (we_q && words_left_q == '0) state_d = StDone;
`endif
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            StChk: begin
                if (rx_ferr) begin
                    state_d = StErr;
                end else if (rx_valid) begin
                    state_d = (rx_byte == csum_q) ? StDone : StErr;
                end
            end
`endif
            StDone: ;
            StErr:  ;
            default: state_d = StErr;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StLen0;
            len_lo_q     <= '0;
            words_left_q <= '0;
            byte_cnt_q   <= '0;
            word_q       <= '0;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            len_lo_q     <= len_lo_d;
            words_left_q <= words_left_d;
            byte_cnt_q   <= byte_cnt_d;
            word_q       <= word_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q       <= csum_d;
`endif
        end
    end

    assign imem_we     = we_q;
    assign imem_addr   = addr_q;
    assign imem_wdata  = wdata_q;
    assign core_resetn = (state_q == StDone);
    assign load_done   = (state_q == StDone);
    assign load_error  = (state_q == StErr);

endmodule

// File: tb/tb_imem_uart_loader.sv
// Directed bench for imem_uart_loader with a write scoreboard; follows
// IMEM_LOADER_CHECKSUM_EN to decide whether a checksum byte is sent.
module tb_imem_uart_loader;

    localparam int unsigned CPB = 8;
    localparam int unsigned AW  = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          uart_rx;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          core_resetn;
    logic          load_done;
    logic          load_error;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    logic [AW+31:0] sb[$];
    logic [AW-1:0]  exp_addr;
    logic [7:0]     csum;

    imem_uart_loader #(
        .CLKS_PER_BIT(CPB),
        .ADDR_WIDTH  (AW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .uart_rx    (uart_rx),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_resetn(core_resetn),
        .load_done  (load_done),
        .load_error (load_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard pops one expected (addr, data) per write strobe.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            logic [AW+31:0] e;
            wr_cnt++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_write: observed addr %0h data %0h expected no write",
                       imem_addr, imem_wdata);
            end else begin
                e = sb.pop_front();
                check("wr_addr", 32'(imem_addr), 32'(e[AW+31:32]));
                check("wr_data", imem_wdata, e[31:0]);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        csum ^= b;
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop_bit;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        sb.push_back({exp_addr, w});
        exp_addr++;
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
    endtask

    task automatic send_len(input logic [15:0] n);
        send_byte(n[7:0], 1'b1);
        send_byte(n[15:8], 1'b1);
    endtask

    task automatic send_csum(input logic [7:0] flip);
`ifdef IMEM_LOADER_CHECKSUM_EN
        logic [7:0] c;
        c = csum ^ flip;
        send_byte(c, 1'b1);
`endif
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        sb.delete();
        exp_addr = '0;
        csum = 8'h00;
        wr_cnt = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_end(input string tag, input int writes, input logic done,
                             input logic err);
        repeat (4) @(negedge clk);
        check({tag, "_writes"}, 32'(wr_cnt), 32'(writes));
        check({tag, "_pending"}, 32'(sb.size()), 32'd0);
        check({tag, "_done"}, 32'(load_done), 32'(done));
        check({tag, "_corern"}, 32'(core_resetn), 32'(done));
        check({tag, "_error"}, 32'(load_error), 32'(err));
    endtask

    initial begin
        uart_rx = 1'b1;
        do_reset();
        check("rst_we", 32'(imem_we), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'd0);
        check("rst_wdata", imem_wdata, 32'd0);
        check("rst_corern", 32'(core_resetn), 32'd0);
        check("rst_done", 32'(load_done), 32'd0);
        check("rst_error", 32'(load_error), 32'd0);

        // Two-word image, then trailing bytes after completion are ignored.
        send_len(16'd2);
        send_word(32'h00500093);
        send_word(32'h00100113);
        send_csum(8'h00);
        check_end("two_words", 2, 1'b1, 1'b0);
        send_byte(8'h55, 1'b1);
        send_byte(8'hAA, 1'b1);
        check_end("after_done", 2, 1'b1, 1'b0);

        // Empty image.
        do_reset();
        send_len(16'd0);
        send_csum(8'h00);
        check_end("empty", 0, 1'b1, 1'b0);

        // Short start glitch is rejected; following image loads normally.
        do_reset();
        uart_rx = 1'b0;
        repeat (2) @(negedge clk);
        uart_rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        check("glitch_error", 32'(load_error), 32'd0);
        send_len(16'd1);
        send_word(32'hCAFE0123);
        send_csum(8'h00);
        check_end("glitch", 1, 1'b1, 1'b0);

        // Framing error on the first byte of the second word.
        do_reset();
        send_len(16'd2);
        send_word(32'h11223344);
        send_byte(8'h99, 1'b0);
        uart_rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check("frame_err_now", 32'(load_error), 32'd1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b1);
        check_end("frame_err", 1, 1'b0, 1'b1);

        // Length one past memory size.
        do_reset();
        send_len(16'h0401);
        check("len_err_now", 32'(load_error), 32'd1);
        for (int i = 0; i < 4; i++) send_byte(8'h5A, 1'b1);
        check_end("len_err", 0, 1'b0, 1'b1);

        // Largest legal length is accepted.
        do_reset();
        send_len(16'h0400);
        check("len_max_ok", 32'(load_error), 32'd0);

        // Reset mid-image, then a fresh one-word image starts at address 0.
        do_reset();
        send_len(16'd2);
        send_word(32'hA5A5A5A5);
        send_byte(8'h10, 1'b1);
        send_byte(8'h20, 1'b1);
        check("pre_reset_writes", 32'(wr_cnt), 32'd1);
        do_reset();
        check("post_reset_addr", 32'(imem_addr), 32'd0);
        send_len(16'd1);
        send_word(32'hDEADBEEF);
        send_csum(8'h00);
        check_end("restart", 1, 1'b1, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Checksum off by one: words stay written, load fails.
        do_reset();
        send_len(16'd2);
        send_word(32'h00500093);
        send_word(32'h00100113);
        send_csum(8'h01);
        check_end("bad_csum", 2, 1'b0, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
